symbol_serializer: RTL and testbench
====================================

SYMBOL_SERIALIZER -- requirements
Module: symbol_serializer

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream word available.
REQ-005 in_ready  output  1  block accepts a word this cycle.
REQ-006 in_data  input  50  ten 5-bit symbols; symbol k = in_data[5k+4:5k], k=0 emitted first.
REQ-007 in_count  input  4  number of symbols to emit, legal range 1..10.
REQ-008 out_valid  output  1  out_sym holds a valid symbol.
REQ-009 out_ready  input  1  downstream accepts the symbol.
REQ-010 out_sym  output  5  current symbol.
REQ-011 out_last  output  1  current symbol is the final symbol of its word.
REQ-012 err  output  1  one-cycle pulse: an illegal-count word was dropped.

Function
REQ-013 The block SHALL be a two-state FSM: IDLE and DRAIN.
REQ-014 IDLE: in_ready=1, out_valid=0.
REQ-015 IDLE, in_valid=1, in_count in 1..10: capture in_data into a 50-bit buffer, load rem=in_count, go to DRAIN next cycle.
REQ-016 IDLE, in_valid=1, in_count=0 or 11..15: word consumed and discarded, err=1 on the following cycle only, stay in IDLE.
REQ-017 DRAIN: out_valid=1, out_sym=buffer[4:0], out_last=(rem==1), all driven from registers.
REQ-018 DRAIN with out_ready=0: out_sym, out_last and out_valid SHALL hold stable.
REQ-019 DRAIN with out_ready=1 and rem>1: buffer shifts right by 5 bits with zero fill, rem decrements by 1.
REQ-020 DRAIN with out_ready=1 and rem==1: word complete, next state per REQ-026/027.
REQ-021 in_ready SHALL be 0 in DRAIN except as REQ-027 allows.
REQ-022 Latency: first symbol SHALL be presented the cycle after acceptance.
REQ-023 Symbols beyond in_count SHALL never be emitted; their buffer contents are don't-care.
REQ-024 rem SHALL be 4 bits and never wrap below 1 while in DRAIN.

Reset
REQ-025 While rst=1: state=IDLE, buffer=0, rem=0, out_valid=0, out_sym=0, out_last=0, err=0, in_ready=0; in_ready returns to 1 the first cycle after deassertion. Reset mid-DRAIN SHALL abandon the word with no further symbols emitted.

Configuration
REQ-026 Without SYM_SER_OVERLAP_EN: completion (REQ-020) returns to IDLE; an N-symbol word occupies N+1 cycles minimum (one bubble between words).
REQ-027 With SYM_SER_OVERLAP_EN defined: in DRAIN, in_ready=out_ready AND (rem==1); a legal word accepted that cycle reloads buffer/rem and stays in DRAIN (zero bubble); an illegal word is dropped with err per REQ-016 and the FSM goes to IDLE; no word -> IDLE.

Verification
REQ-028 Word 0x0_0000_0000_0421 (symbols 1,1,1,0..), count=3, out_ready=1 -> out_sym 1,1,1 on three consecutive cycles, out_last only on third, out_valid low after.
REQ-029 count=10, symbols 0..9, out_ready toggling 1,0,1,0 -> ten symbols 0..9 in order, each held stable while out_ready=0, out_last with symbol 9.
REQ-030 count=0 then count=12 -> no out_valid, err pulses once per word, in_ready remains 1.
REQ-031 Two back-to-back count=2 words, out_ready=1 -> four symbols in 5 cycles without SYM_SER_OVERLAP_EN, 4 cycles with it.
REQ-032 rst asserted after second symbol of a count=5 word -> out_valid=0 immediately, no remaining symbols after release, next word serialized correctly.

Source files
------------

// File: rtl/sym_ser_if.sv
// sym_ser_if: word-in / symbol-out handshake bundle for symbol_serializer
interface sym_ser_if;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] in_data;
  logic [3:0]  in_count;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_sym;
  logic        out_last;
  logic        err;
  modport slave (
    input  in_valid, in_data, in_count, out_ready,
    output in_ready, out_valid, out_sym, out_last, err
  );
  modport master (
    output in_valid, in_data, in_count, out_ready,
    input  in_ready, out_valid, out_sym, out_last, err
  );
endinterface

// File: rtl/symbol_serializer.sv
// symbol_serializer: splits a 50-bit word into up to ten 5-bit symbols; SYM_SER_OVERLAP_EN enables zero-bubble reload
module symbol_serializer (
  input  logic     clk,
  input  logic     rst,
  sym_ser_if.slave bus
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t      state, state_nx;
  logic [49:0] buffer;
  logic [3:0]  rem;
  logic        last_q, err_q;
  logic        legal, take, load, drop, done, shift;
  assign legal = bus.in_count != 4'd0 && bus.in_count <= 4'd10;
  assign take  = bus.in_valid & bus.in_ready;
  assign load  = take & legal;
  assign drop  = take & ~legal;
  assign done  = state == DRAIN && bus.out_ready && rem == 4'd1;
  assign shift = state == DRAIN && bus.out_ready && rem > 4'd1;
  assign bus.out_sym  = buffer[4:0];
  assign bus.out_last = last_q;
  assign bus.err      = err_q;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // next state: a new word can only start from IDLE or on the final symbol
  always_comb begin
    state_nx = (state == IDLE || done) ? (load ? DRAIN : IDLE) : state;
  end
  // outputs: accept only when nothing is pending (or on the last symbol when overlapping)
  always_comb begin
`ifdef SYM_SER_OVERLAP_EN
    bus.in_ready  = state == IDLE ? ~rst : bus.out_ready & (rem == 4'd1);
`else
    bus.in_ready  = state == IDLE & ~rst;
`endif
    bus.out_valid = state == DRAIN;
  end
  // datapath: capture word, shift one symbol out per accepted transfer, flag dropped words
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      buffer <= '0;
      rem    <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= drop;
      if (load) begin
        buffer <= bus.in_data;
        rem    <= bus.in_count;
        last_q <= bus.in_count == 4'd1;
      end else if (shift) begin
        buffer <= {5'd0, buffer[49:5]};
        rem    <= rem - 4'd1;
        last_q <= rem == 4'd2;
      end
    end
endmodule

// File: tb/tb_symbol_serializer.sv
// tb_symbol_serializer: scoreboard bench for symbol_serializer
module tb_symbol_serializer;
  logic clk = 0;
  logic rst = 0;
  sym_ser_if bus ();
  symbol_serializer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int err_seen = 0;
  int err_exp = 0;
  int valid_seen = 0;
  int hs_cnt = 0;
  int hs_cyc[$];
  logic [5:0] exp_q[$];
  logic stall = 0;
  logic [4:0] hold_sym;
  logic hold_last;

  always @(posedge clk) cyc++;

  // monitor: pops expected symbols on every transfer and checks stalls hold steady
  always @(negedge clk) begin
    logic [5:0] e;
    if (rst) stall = 0;
    else begin
      if (bus.err) err_seen++;
      if (bus.out_valid) begin
        valid_seen++;
        if (stall) begin
          checks++;
          if (bus.out_sym !== hold_sym || bus.out_last !== hold_last) begin
            failures++;
            $display("FAIL hold: sym=%0d last=%0b required sym=%0d last=%0b", bus.out_sym, bus.out_last, hold_sym, hold_last);
          end
        end
        if (bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_symbol: sym=%0d last=%0b required none", bus.out_sym, bus.out_last);
          end else begin
            e = exp_q.pop_front();
            if ({bus.out_last, bus.out_sym} !== e) begin
              failures++;
              $display("FAIL symbol: sym=%0d last=%0b required sym=%0d last=%0b", bus.out_sym, bus.out_last, e[4:0], e[5]);
            end
          end
          hs_cnt++;
          hs_cyc.push_back(cyc);
        end
        stall = !bus.out_ready;
        hold_sym = bus.out_sym;
        hold_last = bus.out_last;
      end else stall = 0;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic send(input logic [49:0] d, input logic [3:0] c);
    int n = 0;
    logic ok = 0;
    bus.in_valid = 1;
    bus.in_data = d;
    bus.in_count = c;
    if (c >= 1 && c <= 10)
      for (int k = 0; k < int'(c); k++) exp_q.push_back({k == int'(c) - 1, d[5*k +: 5]});
    else err_exp++;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    check("accept", int'(ok), 1);
    bus.in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int base, span, vs;
    logic [49:0] d;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_count = '0;
    bus.out_ready = 0;
    #1 rst = 1;
    #6;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_out_sym", int'(bus.out_sym), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("in_ready_after_rst", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // three ones, continuous ready
    bus.out_ready = 1;
    base = hs_cnt;
    send(50'h421, 4'd3);
    drain();
    check("ones_count", hs_cnt - base, 3);
    if (hs_cnt - base == 3) check("ones_consecutive", hs_cyc[base+2] - hs_cyc[base], 2);
    check("ones_valid_after", int'(bus.out_valid), 0);

    // ten symbols 0..9 with alternating ready
    d = '0;
    for (int k = 0; k < 10; k++) d[5*k +: 5] = 5'(k);
    base = hs_cnt;
    send(d, 4'd10);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(posedge clk);
        #1;
        bus.out_ready = ~bus.out_ready;
        n++;
      end
    end
    bus.out_ready = 1;
    drain();
    check("ten_count", hs_cnt - base, 10);

    // illegal counts are dropped with an err pulse each
    vs = valid_seen;
    send(50'h3ff, 4'd0);
    @(negedge clk);
    check("illegal0_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    send(50'h3ff, 4'd12);
    @(negedge clk);
    check("illegal12_in_ready", int'(bus.in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    check("illegal_no_valid", valid_seen - vs, 0);
    check("illegal_err_pulses", err_seen, err_exp);

    // back-to-back two-symbol words
    base = hs_cnt;
    send(50'h0a5, 4'd2);
    send(50'h1e7, 4'd2);
    drain();
    check("b2b_count", hs_cnt - base, 4);
`ifdef SYM_SER_OVERLAP_EN
    if (hs_cnt - base == 4) check("b2b_span", hs_cyc[base+3] - hs_cyc[base], 3);
`else
    if (hs_cnt - base == 4) check("b2b_span", hs_cyc[base+3] - hs_cyc[base], 4);
`endif

    // reset in the middle of a five-symbol word
    d = '0;
    for (int k = 0; k < 5; k++) d[5*k +: 5] = 5'(11 + k);
    base = hs_cnt;
    send(d, 4'd5);
    begin
      int n = 0;
      while (hs_cnt - base < 2 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    rst = 1;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_handshakes", hs_cnt - base, 2);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    vs = valid_seen;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_valid", valid_seen - vs, 0);
    base = hs_cnt;
    send(50'h3e2, 4'd2);
    drain();
    check("post_rst_count", hs_cnt - base, 2);
    check("final_err_pulses", err_seen, err_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
